// File: rtl/game_input_ctrl.sv
// Button front-end: synchronise and debounce five raw buttons and turn each clean press into one
// move command, held in a single-entry slot and handed off on a valid/ready handshake.
module game_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_new,
  output logic       cmd_valid,
  output logic       cmd_new,
  output logic [1:0] cmd_dir,
  input  logic       cmd_ready,
  output logic [4:0] btn_state
);

  localparam logic             EMPTY    = 1'b0;
  localparam logic             PENDING  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order {new, left, down, right, up}: bits 0..3 double as the direction code.
  logic [4:0]       raw;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       stable;
  logic [4:0]       stable_q;
  logic [CNT_W-1:0] cnt [5];
  logic [4:0]       press;
  logic [1:0]       sel_dir;
  logic             state;

  assign raw = {btn_new, btn_left, btn_down, btn_right, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only 0->1 of the debounced level counts; releases never produce a command.
  assign press = stable & ~stable_q;

  always_comb begin
    sel_dir = 2'd0;
    if (!press[4]) begin
      if (press[0])      sel_dir = 2'd0;
      else if (press[1]) sel_dir = 2'd1;
      else if (press[2]) sel_dir = 2'd2;
      else if (press[3]) sel_dir = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      cmd_new <= 1'b0;
      cmd_dir <= 2'd0;
    end else if (state == EMPTY) begin
      if (|press) begin
        state   <= PENDING;
        cmd_new <= press[4];
        cmd_dir <= sel_dir;
      end
    end else begin
      // A handshake wins over any press in the same cycle; only new-game may replace a waiting move.
      if (cmd_ready) begin
        state   <= EMPTY;
        cmd_new <= 1'b0;
        cmd_dir <= 2'd0;
      end else if (press[4]) begin
        cmd_new <= 1'b1;
        cmd_dir <= 2'd0;
      end
    end
  end

  assign cmd_valid = (state == PENDING);
  assign btn_state = stable;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Bench for game_input_ctrl with a 4-cycle debounce: directed scenarios push expected commands,
// a monitor pops and compares them on every handshake.
module tb_game_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_right, btn_down, btn_left, btn_new;
  logic       cmd_valid, cmd_new, cmd_ready;
  logic [1:0] cmd_dir;
  logic [4:0] btn_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  logic [2:0] exp_q [$];

  game_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
    .btn_left(btn_left), .btn_new(btn_new),
    .cmd_valid(cmd_valid), .cmd_new(cmd_new), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted command must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_cmd: got new=%0b dir=%0d, expected no command", cmd_new, cmd_dir);
      end else begin
        check("cmd_content", {29'd0, cmd_new, cmd_dir}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, cmd_valid}, 32'd1);
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
  endtask

  int hs_base;

  initial begin
    rst = 1'b1; cmd_ready = 1'b0;
    btn_up = 0; btn_right = 0; btn_down = 0; btn_left = 0; btn_new = 0;
    tick(3);
    check("reset_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_new", {31'd0, cmd_new}, 32'd0);
    check("reset_dir", {30'd0, cmd_dir}, 32'd0);
    check("reset_btn_state", {27'd0, btn_state}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Clean press: raw change after edge E, stable after E+6, valid after E+7.
    btn_up = 1'b1;
    tick(5);
    check("up_state_early", {31'd0, btn_state[0]}, 32'd0);
    tick(1);
    check("up_state_e6", {31'd0, btn_state[0]}, 32'd1);
    check("up_valid_e6", {31'd0, cmd_valid}, 32'd0);
    tick(1);
    check("up_valid_e7", {31'd0, cmd_valid}, 32'd1);
    check("up_dir", {30'd0, cmd_dir}, 32'd0);
    check("up_new", {31'd0, cmd_new}, 32'd0);
    tick(3);
    check("up_held", {31'd0, cmd_valid}, 32'd1);
    exp_q.push_back(3'b000);
    handshake();
    check("up_drop", {31'd0, cmd_valid}, 32'd0);
    tick(10);
    check("up_no_repeat", {31'd0, cmd_valid}, 32'd0);
    btn_up = 1'b0;
    tick(10);
    check("up_release_no_cmd", {31'd0, cmd_valid}, 32'd0);

    // Glitch rejection, then a real press.
    btn_left = 1'b1;
    tick(3);
    btn_left = 1'b0;
    tick(12);
    check("glitch_state", {27'd0, btn_state}, 32'd0);
    check("glitch_valid", {31'd0, cmd_valid}, 32'd0);
    btn_left = 1'b1;
    tick(8);
    check("left_valid", {31'd0, cmd_valid}, 32'd1);
    check("left_dir", {30'd0, cmd_dir}, 32'd3);
    exp_q.push_back(3'b011);
    handshake();
    btn_left = 1'b0;
    tick(10);

    // Simultaneous presses: right beats down, down is discarded.
    btn_down = 1'b1; btn_right = 1'b1;
    wait_valid("simul_valid");
    check("simul_dir", {30'd0, cmd_dir}, 32'd1);
    exp_q.push_back(3'b001);
    handshake();
    tick(10);
    check("simul_no_followup", {31'd0, cmd_valid}, 32'd0);
    btn_down = 1'b0; btn_right = 1'b0;
    tick(10);

    // Overwrite and drop while pending.
    btn_right = 1'b1;
    tick(8);
    check("ovr_right_dir", {30'd0, cmd_dir}, 32'd1);
    btn_left = 1'b1;
    tick(8);
    check("ovr_left_dropped_dir", {30'd0, cmd_dir}, 32'd1);
    check("ovr_left_dropped_new", {31'd0, cmd_new}, 32'd0);
    btn_new = 1'b1;
    tick(8);
    check("ovr_new_flag", {31'd0, cmd_new}, 32'd1);
    check("ovr_new_dir", {30'd0, cmd_dir}, 32'd0);
    exp_q.push_back(3'b100);
    handshake();
    check("ovr_after_hs", {31'd0, cmd_valid}, 32'd0);
    btn_right = 1'b0; btn_left = 1'b0; btn_new = 1'b0;
    tick(10);
    check("ovr_idle", {31'd0, cmd_valid}, 32'd0);

    // Release/repress gives exactly two commands.
    hs_base = n_hs;
    btn_up = 1'b1;
    wait_valid("rep_first_valid");
    exp_q.push_back(3'b000);
    handshake();
    btn_up = 1'b0;
    tick(6);
    btn_up = 1'b1;
    wait_valid("rep_second_valid");
    exp_q.push_back(3'b000);
    handshake();
    btn_up = 1'b0;
    tick(10);
    check("rep_idle", {31'd0, cmd_valid}, 32'd0);
    check("rep_count", n_hs - hs_base, 32'd2);

    // Reset with a command pending; held button re-debounces from scratch.
    btn_down = 1'b1;
    wait_valid("rst_pre_valid");
    check("rst_pre_dir", {30'd0, cmd_dir}, 32'd2);
    rst = 1'b1;
    tick(1);
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_new", {31'd0, cmd_new}, 32'd0);
    check("rst_dir", {30'd0, cmd_dir}, 32'd0);
    check("rst_btn_state", {27'd0, btn_state}, 32'd0);
    rst = 1'b0;
    tick(6);
    check("rst_valid_r6", {31'd0, cmd_valid}, 32'd0);
    tick(1);
    check("rst_valid_r7", {31'd0, cmd_valid}, 32'd1);
    check("rst_dir_r7", {30'd0, cmd_dir}, 32'd2);
    exp_q.push_back(3'b010);
    handshake();
    btn_down = 1'b0;
    tick(10);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
